// File: rtl/str_pkg.sv
// Shared definitions for the str_fifo slice: default data width, pointer width helper and the
// pointer typedef pattern (one extra wrap bit above the index bits).
package str_pkg;

  localparam int unsigned StrDefaultVw = 32;
  localparam int unsigned StrMaxDepth  = 256;

  // Index bits plus one wrap bit, so full and empty can be told apart when indices match.
  function automatic int unsigned str_ptr_w(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned StrMaxPtrW = str_ptr_w(StrMaxDepth);

  // Modules declare their own pointer type the same way, sized with str_ptr_w(DEPTH).
  typedef logic [StrMaxPtrW-1:0] str_ptr_max_t;

endpackage

// File: rtl/str_fifo_mem.sv
// Storage array for str_fifo: one write port and a read port with a registered address.
// The array itself is never reset.
module str_fifo_mem #(
  parameter int unsigned  Width = 32,
  parameter int unsigned  Depth = 4,
  localparam int unsigned AW    = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    raddr_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    raddr_q <= raddr_i;
  end

  assign rdata_o = mem_q[raddr_q];

endmodule

// File: rtl/str_fifo.sv
// Registered-handshake stream FIFO with 1-cycle fill latency and no bypass.
// Define STR_FIFO_LEVEL_EN to add the registered occupancy output `level`.
module str_fifo
  import str_pkg::*;
#(
  parameter int unsigned VW    = StrDefaultVw,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic [VW-1:0] s_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [VW-1:0] m_tdata
`ifdef STR_FIFO_LEVEL_EN
  ,
  output logic [str_ptr_w(DEPTH)-1:0] level
`endif
);

  localparam int unsigned PtrW = str_ptr_w(DEPTH);
  localparam int unsigned IdxW = PtrW - 1;

  typedef logic [PtrW-1:0] ptr_t;

  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  logic s_tready_q, m_tvalid_q;
  logic push, pop;
  logic full_d, empty_d;

  // Handshake flags are computed from the next pointers so they can be registered directly.
  always_comb begin
    push    = s_tvalid & s_tready_q;
    pop     = m_tvalid_q & m_tready;
    wptr_d  = push ? wptr_q + ptr_t'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + ptr_t'(1) : rptr_q;
    full_d  = (wptr_d[IdxW-1:0] == rptr_d[IdxW-1:0]) && (wptr_d[PtrW-1] != rptr_d[PtrW-1]);
    empty_d = (wptr_d == rptr_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      s_tready_q <= !full_d;
      m_tvalid_q <= !empty_d;
    end
  end

  assign s_tready = s_tready_q;
  assign m_tvalid = m_tvalid_q;

  // Read address tracks the next head, so a fresh word is visible right after its write edge.
  str_fifo_mem #(
    .Width (VW),
    .Depth (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wptr_q[IdxW-1:0]),
    .wdata_i (s_tdata),
    .raddr_i (rptr_d[IdxW-1:0]),
    .rdata_o (m_tdata)
  );

`ifdef STR_FIFO_LEVEL_EN
  ptr_t level_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= '0;
    end else begin
      level_q <= wptr_d - rptr_d;
    end
  end

  assign level = level_q;
`endif

endmodule

// File: tb/tb_str_fifo.sv
// Self-checking bench for str_fifo (VW=32, DEPTH=4) against a queue-based reference model.
module tb_str_fifo;

  localparam int unsigned VW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          s_tvalid;
  logic          s_tready;
  logic [VW-1:0] s_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [VW-1:0] m_tdata;
`ifdef STR_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  str_fifo #(
    .VW    (VW),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata)
`ifdef STR_FIFO_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: contents as a queue plus expected handshake flags.
  logic [VW-1:0] q[$];
  logic          exp_ready = 1'b0;
  logic          exp_valid = 1'b0;
  logic          last_acc;
  logic          last_pop;
  logic [VW-1:0] obs_word;
  logic [VW-1:0] exp_word;

  // Drive one cycle of stimulus, advance the model across the rising edge, return at negedge.
  task automatic cycle(input logic v, input logic [VW-1:0] d, input logic r);
    s_tvalid = v;
    s_tdata  = d;
    m_tready = r;
    last_acc = v && exp_ready;
    last_pop = exp_valid && r;
    obs_word = m_tdata;
    exp_word = (q.size() != 0) ? q[0] : '0;
    @(posedge clk);
    if (last_pop) q.delete(0);
    if (last_acc) q.push_back(d);
    exp_ready = (q.size() < DEPTH);
    exp_valid = (q.size() != 0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_tvalid = 1'b0;
    s_tdata = '0;
    m_tready = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_s_tready: got %b want 0", s_tready);
    end
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_m_tvalid: got %b want 0", m_tvalid);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, '0, 1'b0);
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_s_tready: got %b want 1", s_tready);
    end
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_m_tvalid: got %b want 0", m_tvalid);
    end
  endtask

  task automatic test_first_data();
    cycle(1'b1, 32'hA5A5_0001, 1'b0);
    checks++;
    if (m_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL first_m_tvalid: got %b want 1", m_tvalid);
    end
    checks++;
    if (m_tdata !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL first_m_tdata: got %h want a5a50001", m_tdata);
    end
`ifdef STR_FIFO_LEVEL_EN
    checks++;
    if (level !== 3'd1) begin
      errors++;
      $display("FAIL first_level: got %0d want 1", level);
    end
`endif
    cycle(1'b0, '0, 1'b1);
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL first_drain_m_tvalid: got %b want 0", m_tvalid);
    end
  endtask

  task automatic test_fill_full();
    logic [VW-1:0] w5;
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0);
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL fill_s_tready: got %b want 0", s_tready);
    end
`ifdef STR_FIFO_LEVEL_EN
    checks++;
    if (level !== 3'd4) begin
      errors++;
      $display("FAIL fill_level: got %0d want 4", level);
    end
`endif
    w5 = $urandom;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, w5, 1'b0);
      checks++;
      if (s_tready !== 1'b0) begin
        errors++;
        $display("FAIL held_s_tready: got %b want 0", s_tready);
      end
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== q[0]) begin
        errors++;
        $display("FAIL held_head: got v=%b d=%h want v=1 d=%h", m_tvalid, m_tdata, q[0]);
      end
`ifdef STR_FIFO_LEVEL_EN
      checks++;
      if (level !== 3'd4) begin
        errors++;
        $display("FAIL held_level: got %0d want 4", level);
      end
`endif
    end
  endtask

  task automatic test_pop_when_full();
    logic [VW-1:0] w = $urandom;
    cycle(1'b1, w, 1'b1);
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL popfull_s_tready: got %b want 1", s_tready);
    end
    checks++;
    if (obs_word !== exp_word) begin
      errors++;
      $display("FAIL popfull_word: got %h want %h", obs_word, exp_word);
    end
`ifdef STR_FIFO_LEVEL_EN
    checks++;
    if (level !== 3'd3) begin
      errors++;
      $display("FAIL popfull_level: got %0d want 3", level);
    end
`endif
    cycle(1'b1, w, 1'b0);
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL refill_s_tready: got %b want 0", s_tready);
    end
`ifdef STR_FIFO_LEVEL_EN
    checks++;
    if (level !== 3'd4) begin
      errors++;
      $display("FAIL refill_level: got %0d want 4", level);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1);
      checks++;
      if (obs_word !== exp_word) begin
        errors++;
        $display("FAIL drain_word%0d: got %h want %h", i, obs_word, exp_word);
      end
    end
    checks++;
    if (obs_word !== w) begin
      errors++;
      $display("FAIL held_word_last: got %h want %h", obs_word, w);
    end
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL drained_m_tvalid: got %b want 0", m_tvalid);
    end
  endtask

  task automatic test_wrap();
    int n_in = 0;
    int n_out = 0;
    for (int c = 0; c < 1000 && n_out < 20; c++) begin
      cycle((n_in < 20) && ($urandom_range(1, 0) == 1), VW'(n_in), $urandom_range(1, 0) == 1);
      if (last_acc) n_in++;
      if (last_pop) begin
        checks++;
        if (obs_word !== VW'(n_out)) begin
          errors++;
          $display("FAIL wrap_order: got %0d want %0d", obs_word, n_out);
        end
        n_out++;
      end
      checks++;
      if (s_tready !== exp_ready || m_tvalid !== exp_valid) begin
        errors++;
        $display("FAIL wrap_flags: got r=%b v=%b want r=%b v=%b",
                 s_tready, m_tvalid, exp_ready, exp_valid);
      end
    end
    checks++;
    if (n_out != 20) begin
      errors++;
      $display("FAIL wrap_count: got %0d words want 20 (cycle budget expired)", n_out);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, $urandom, 1'b0);
    cycle(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, $urandom, 1'b1);
      checks++;
      if (obs_word !== exp_word) begin
        errors++;
        $display("FAIL b2b_word%0d: got %h want %h", i, obs_word, exp_word);
      end
      checks++;
      if (s_tready !== 1'b1 || m_tvalid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_flags%0d: got r=%b v=%b want r=1 v=1", i, s_tready, m_tvalid);
      end
`ifdef STR_FIFO_LEVEL_EN
      checks++;
      if (level !== 3'd2) begin
        errors++;
        $display("FAIL b2b_level%0d: got %0d want 2", i, level);
      end
`endif
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, '0, 1'b1);
      checks++;
      if (obs_word !== exp_word) begin
        errors++;
        $display("FAIL b2b_drain%0d: got %h want %h", i, obs_word, exp_word);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [VW-1:0] wn;
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0);
    s_tvalid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_flags: got v=%b r=%b want v=0 r=0", m_tvalid, s_tready);
    end
`ifdef STR_FIFO_LEVEL_EN
    checks++;
    if (level !== 3'd0) begin
      errors++;
      $display("FAIL midrst_level: got %0d want 0", level);
    end
`endif
    q.delete();
    exp_ready = 1'b0;
    exp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
      errors++;
      $display("FAIL postrst_flags: got v=%b r=%b want v=0 r=1", m_tvalid, s_tready);
    end
`ifdef STR_FIFO_LEVEL_EN
    checks++;
    if (level !== 3'd0) begin
      errors++;
      $display("FAIL postrst_level: got %0d want 0", level);
    end
`endif
    wn = $urandom;
    cycle(1'b1, wn, 1'b0);
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== wn) begin
      errors++;
      $display("FAIL postrst_word: got v=%b d=%h want v=1 d=%h", m_tvalid, m_tdata, wn);
    end
    cycle(1'b0, '0, 1'b1);
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL postrst_drain: got %b want 0", m_tvalid);
    end
  endtask

  initial begin
    test_reset();
    test_first_data();
    test_fill_full();
    test_pop_when_full();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
